sim_exit_ctrl: RTL
==================

# sim_exit_ctrl

Parametrised run-control block for the HEEPsilon simulation harness. It sequences the system reset release and latches boot strapping. It watches N exit channels, for example the CPU exit plus CGRA or accelerator self-checks. It enforces a cycle budget with a watchdog and reports one registered pass, fail or timeout verdict. It is synthesisable, so the same logic serves RTL simulation, FPGA emulation and post-synthesis runs.

## Interface
Parameters:
- `N_CH`, 2: number of exit channels (≥1).
- `VALUE_W`, 32: width of each exit value.
- `CNT_W`, 32: width of the cycle counter and budget.
- `RESET_WAIT_CYCLES`, 50: cycles the system reset is held after `rst_ni` deasserts (≥1).
- `STOP_ON_FAIL`, 1: 1 means the first failing exit ends the run; 0 means the block waits for all enabled channels.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `boot_select_i`  in  1  boot strap: 0 = JTAG, 1 = flash.
- `execute_from_flash_i`  in  1  SPI mode strap.
- `ch_en_i`  in  N_CH  channel enable mask.
- `max_cycles_i`  in  CNT_W  cycle budget; 0 disables the watchdog.
- `exit_valid_i`  in  N_CH  per-channel exit strobe.
- `exit_value_i`  in  N_CH×VALUE_W  per-channel exit value; 0 means success.
- `sys_rst_no`  out  1  reset to the system under test.
- `boot_select_o`, `execute_from_flash_o`  out  1  latched straps.
- `cycle_cnt_o`  out  CNT_W  cycles spent in RUN.
- `done_o`, `pass_o`, `timeout_o`  out  1  verdict outputs.
- `fail_mask_o`  out  N_CH  channels that exited with a nonzero value.
- `exit_code_o`  out  VALUE_W  first failing value.
- `exit_ch_o`  out  max(1,$clog2(N_CH))  index of the first failing channel.

## Operation
- FSM states: HOLD → RUN → DONE. DONE is sticky until `rst_ni` asserts.
- Reset value of every output is 0. This includes `sys_rst_no`, which is therefore held in reset.
- HOLD:
  - The wait counter counts up from 0.
  - When the counter reaches `RESET_WAIT_CYCLES-1`, the FSM moves to RUN.
  - On that transition the block latches `boot_select_i`, `execute_from_flash_i`, `ch_en_i` and `max_cycles_i`. These inputs are ignored at all other times.
  - `sys_rst_no` goes to 1 registered, in the first RUN cycle.
- RUN:
  - `cycle_cnt_o` increments each cycle and saturates at all-ones.
  - An `exit_valid_i[k]` strobe is accepted only if channel k is enabled and has not exited yet. Later strobes on that channel are ignored.
  - Each accepted strobe sets an internal exited bit for channel k.
  - A nonzero value also sets `fail_mask_o[k]`.
  - The first failure records `exit_code_o` and `exit_ch_o`. If several channels fail in the same cycle, the lowest index wins.
- Transition to DONE happens when any of these holds:
  - All enabled channels have exited.
  - `STOP_ON_FAIL`=1 and any failure has been accepted.
  - The watchdog is enabled and `cycle_cnt_o` ≥ the latched budget. `timeout_o` is then set.
- Simultaneous exit and timeout: the exit is accepted and the timeout is suppressed (`timeout_o`=0) if that exit completes the run.
- Empty enable mask: exits can never complete the run. Only the watchdog ends it; with a zero budget the block runs forever.
- DONE:
  - All outputs freeze and strobes are ignored.
  - `pass_o` = !`timeout_o` && `fail_mask_o`==0.
  - `sys_rst_no` stays 1.
- Reset mid-operation: all state clears asynchronously and the FSM returns to HOLD.

## Timing
- `sys_rst_no` rises exactly `RESET_WAIT_CYCLES` rising edges after the first edge with `rst_ni` high.
- Verdict latency:
  - `done_o` and the verdict outputs rise 1 cycle after the edge that samples the completing strobe.
  - For a timeout, they rise 1 cycle after `cycle_cnt_o` equals the budget.
- `cycle_cnt_o` is 0 in the first RUN cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The exit strobe is level-sampled at each edge. No handshake is returned; the producer may hold the strobe high.

## Structure
- Package `sim_exit_ctrl_pkg` holds the state enum `exit_state_e` {HOLD, RUN, DONE}.
- One natural sub-module, `exit_ch_tracker`, is instantiated once per channel. It holds the exited and fail bits and produces accept and fail pulses.
- The top level holds the FSM, the counters and the lowest-index priority selection of the first failure.

## Test plan
- Reset sequencing: `rst_ni` released with `RESET_WAIT_CYCLES`=50 and `boot_select_i`=1 → `sys_rst_no` rises on edge 50 and `boot_select_o`=1. Changing the straps afterwards has no effect.
- Two-channel pass: ch0 exits with 0 at cycle 100 and ch1 exits with 0 at cycle 200 → `done_o` one cycle later, `pass_o`=1, `fail_mask_o`=00.
- Fail priority: both channels exit in the same cycle, ch0 with 5 and ch1 with 7 → `exit_code_o`=5, `exit_ch_o`=0, `fail_mask_o`=11, `pass_o`=0.
- Watchdog: `max_cycles_i`=1000 and no exits → `timeout_o`=1 and `done_o`=1 when `cycle_cnt_o`=1000. An exit arriving later is ignored.
- Disabled channel and stop mode: `ch_en_i`=01 and ch1 strobes 3 → ignored. With `STOP_ON_FAIL`=0, ch0 exits with 9 → DONE with `fail_mask_o`=01.
- Mid-run reset: assert `rst_ni` during RUN → all outputs are 0 immediately and the HOLD sequence repeats.

Source files
------------

// File: rtl/sim_exit_ctrl_pkg.sv
// Shared types for the simulation run-control block.
package sim_exit_ctrl_pkg;

  // Run-control sequence: hold the system in reset, run it, then freeze the verdict.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } exit_state_e;

endpackage

// File: rtl/exit_ch_tracker.sv
// Per-channel exit bookkeeping: remembers whether the channel has exited and
// whether it exited with a failing value. Only the first strobe is taken.
module exit_ch_tracker (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run,
  input  logic en,
  input  logic valid,
  input  logic nz,
  output logic exited,
  output logic fail,
  output logic accept,
  output logic fail_pulse
);

  // A strobe counts only while running, on an enabled channel that has not yet exited.
  always_comb begin
    accept     = run & en & valid & ~exited;
    fail_pulse = accept & nz;
  end

  // Sticky exited/fail bits; they only clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exited <= 1'b0;
      fail   <= 1'b0;
    end else begin
      if (accept)     exited <= 1'b1;
      if (fail_pulse) fail   <= 1'b1;
    end
  end

endmodule

// File: rtl/sim_exit_ctrl.sv
// Run-control for the simulation harness: sequences system reset release,
// latches the boot straps, collects per-channel exits, runs a cycle-budget
// watchdog and reports a single registered pass/fail/timeout verdict.
module sim_exit_ctrl
  import sim_exit_ctrl_pkg::*;
#(
  parameter int N_CH              = 2,
  parameter int VALUE_W           = 32,
  parameter int CNT_W             = 32,
  parameter int RESET_WAIT_CYCLES = 50,
  parameter int STOP_ON_FAIL      = 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      boot_select_i,
  input  logic                                      execute_from_flash_i,
  input  logic [N_CH-1:0]                           ch_en_i,
  input  logic [CNT_W-1:0]                          max_cycles_i,
  input  logic [N_CH-1:0]                           exit_valid_i,
  input  logic [N_CH*VALUE_W-1:0]                   exit_value_i,
  output logic                                      sys_rst_no,
  output logic                                      boot_select_o,
  output logic                                      execute_from_flash_o,
  output logic [CNT_W-1:0]                          cycle_cnt_o,
  output logic                                      done_o,
  output logic                                      pass_o,
  output logic                                      timeout_o,
  output logic [N_CH-1:0]                           fail_mask_o,
  output logic [VALUE_W-1:0]                        exit_code_o,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] exit_ch_o
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WAIT_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESET_WAIT_CYCLES - 1);

  exit_state_e         state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [N_CH-1:0]     en_q;
  logic [CNT_W-1:0]    budget_q;

  logic                run;
  logic [N_CH-1:0]     value_nz;
  logic [N_CH-1:0]     exited;
  logic [N_CH-1:0]     accept;
  logic [N_CH-1:0]     fail_pulse;
  logic                all_exit;
  logic                stop_fail;
  logic                wd_hit;
  logic [CH_W-1:0]     first_idx;
  logic [VALUE_W-1:0]  first_val;

  assign run = (state == RUN);

  // One tracker per channel; its fail bit is the registered fail mask.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign value_nz[k] = |exit_value_i[k*VALUE_W +: VALUE_W];

    exit_ch_tracker u_trk (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .run        (run),
      .en         (en_q[k]),
      .valid      (exit_valid_i[k]),
      .nz         (value_nz[k]),
      .exited     (exited[k]),
      .fail       (fail_mask_o[k]),
      .accept     (accept[k]),
      .fail_pulse (fail_pulse[k])
    );
  end

  // Completion conditions; an empty enable mask can never complete by exits.
  always_comb begin
    all_exit  = (en_q != '0) && (((exited | accept) & en_q) == en_q);
    stop_fail = (STOP_ON_FAIL != 0) && (fail_pulse != '0);
    wd_hit    = (budget_q != '0) && (cycle_cnt_o >= budget_q);
  end

  // Lowest-index failing channel this cycle (scan high to low so low wins).
  always_comb begin
    first_idx = '0;
    first_val = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (fail_pulse[k]) begin
        first_idx = CH_W'(k);
        first_val = exit_value_i[k*VALUE_W +: VALUE_W];
      end
    end
  end

  // Run-control FSM with registered outputs; an exit that completes the run
  // takes precedence over a watchdog hit in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                <= HOLD;
      wait_cnt             <= '0;
      en_q                 <= '0;
      budget_q             <= '0;
      sys_rst_no           <= 1'b0;
      boot_select_o        <= 1'b0;
      execute_from_flash_o <= 1'b0;
      cycle_cnt_o          <= '0;
      done_o               <= 1'b0;
      pass_o               <= 1'b0;
      timeout_o            <= 1'b0;
      exit_code_o          <= '0;
      exit_ch_o            <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (wait_cnt == WAIT_LAST) begin
            state                <= RUN;
            sys_rst_no           <= 1'b1;
            boot_select_o        <= boot_select_i;
            execute_from_flash_o <= execute_from_flash_i;
            en_q                 <= ch_en_i;
            budget_q             <= max_cycles_i;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RUN: begin
          if ((fail_pulse != '0) && (fail_mask_o == '0)) begin
            exit_code_o <= first_val;
            exit_ch_o   <= first_idx;
          end
          if (all_exit || stop_fail) begin
            state  <= DONE;
            done_o <= 1'b1;
            pass_o <= ((fail_mask_o | fail_pulse) == '0);
          end else if (wd_hit) begin
            state     <= DONE;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
          end else if (cycle_cnt_o != '1) begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
